// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : icache_pkg
//  Brief   : Shared types and default widths for the i-cache array arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
package icache_pkg;

  localparam int DEF_XLEN             = 32;
  localparam int DEF_DATA_WIDTH       = 32;
  localparam int DEF_SETIDXBITS       = 5;
  localparam int DEF_BLOCK_OFFSETBITS = 1;
  localparam int DEF_WORD_OFFSETBITS  = 1;
  localparam int DEF_WID_BITS         = 3;

  localparam int TAGBITS   = DEF_XLEN - DEF_SETIDXBITS - DEF_BLOCK_OFFSETBITS - DEF_WORD_OFFSETBITS;
  localparam int NUM_BEATS = 1 << DEF_WORD_OFFSETBITS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } arb_state_e;

  // One entry of the registered array request stage (sized by the package defaults).
  typedef struct packed {
    logic                           valid;
    logic                           we;
    logic [DEF_SETIDXBITS-1:0]      setid;
    logic [TAGBITS-1:0]             tag;
    logic [DEF_WORD_OFFSETBITS-1:0] word;
    logic [DEF_DATA_WIDTH-1:0]      wdata;
    logic [DEF_WID_BITS-1:0]        wid;
  } arr_req_t;

endpackage
`default_nettype wire

// File: rtl/icache_addr_split.sv
`default_nettype none
// ============================================================================
//  Module  : icache_addr_split
//  Brief   : Pure bit-select split of a byte address into tag / set / word.
//  Rev     : 1.0  initial release
// ============================================================================
module icache_addr_split #(
  parameter int XLEN             = 32,
  parameter int SETIDXBITS       = 5,
  parameter int BLOCK_OFFSETBITS = 1,
  parameter int WORD_OFFSETBITS  = 1
) (
  input  logic [XLEN-1:0]                                            addr,
  output logic [XLEN-SETIDXBITS-BLOCK_OFFSETBITS-WORD_OFFSETBITS-1:0] tag,
  output logic [SETIDXBITS-1:0]                                      setid,
  output logic [WORD_OFFSETBITS-1:0]                                 word
);

  localparam int LOW = BLOCK_OFFSETBITS + WORD_OFFSETBITS;

  assign tag   = addr[XLEN-1 : SETIDXBITS+LOW];
  assign setid = addr[SETIDXBITS+LOW-1 : LOW];
  assign word  = addr[LOW-1 : BLOCK_OFFSETBITS];

  // Byte-in-word bits carry no meaning for a word-granular array.
  generate
    if (BLOCK_OFFSETBITS > 0) begin : g_byte_off
      logic unused_byte_bits;
      assign unused_byte_bits = ^addr[BLOCK_OFFSETBITS-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/icache_array_arb.sv
`default_nettype none
// ============================================================================
//  Module  : icache_array_arb
//  Brief   : Arbitrates the single-port i-cache array between fetch lookups
//            and multi-beat refill writes, with bounded core starvation.
//  Rev     : 1.0  initial release
// ============================================================================
module icache_array_arb
  import icache_pkg::*;
#(
  parameter int XLEN             = DEF_XLEN,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int SETIDXBITS       = DEF_SETIDXBITS,
  parameter int BLOCK_OFFSETBITS = DEF_BLOCK_OFFSETBITS,
  parameter int WORD_OFFSETBITS  = DEF_WORD_OFFSETBITS,
  parameter int WID_BITS         = DEF_WID_BITS,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic                                                        clk,
  input  logic                                                        rst_n,
  input  logic                                                        core_req_valid_i,
  output logic                                                        core_req_ready_o,
  input  logic [XLEN-1:0]                                             core_req_addr_i,
  input  logic [WID_BITS-1:0]                                         core_req_wid_i,
  input  logic                                                        fill_valid_i,
  output logic                                                        fill_ready_o,
  input  logic [XLEN-1:0]                                             fill_addr_i,
  input  logic [DATA_WIDTH-1:0]                                       fill_data_i,
  input  logic                                                        fill_last_i,
  input  logic                                                        arr_ready_i,
  output logic                                                        arr_valid_o,
  output logic                                                        arr_we_o,
  output logic [SETIDXBITS-1:0]                                       arr_setid_o,
  output logic [XLEN-SETIDXBITS-BLOCK_OFFSETBITS-WORD_OFFSETBITS-1:0] arr_tag_o,
  output logic [WORD_OFFSETBITS-1:0]                                  arr_word_o,
  output logic [DATA_WIDTH-1:0]                                       arr_wdata_o,
  output logic [WID_BITS-1:0]                                         arr_wid_o,
  output logic                                                        err_o
);

  localparam int TAG_W    = XLEN - SETIDXBITS - BLOCK_OFFSETBITS - WORD_OFFSETBITS;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0]        STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [WORD_OFFSETBITS-1:0] LAST_BEAT  = {WORD_OFFSETBITS{1'b1}};

  arb_state_e                 state, state_next;
  logic [WORD_OFFSETBITS-1:0] beat, beat_next;
  logic [STARVE_W-1:0]        starve, starve_next;
  arr_req_t                   req_q, req_d;
  logic                       err_q, err_next;
  logic                       alive;

  logic adv, fill_pri, grant_fill, grant_core;

  logic [TAG_W-1:0]           core_tag, fill_tag;
  logic [SETIDXBITS-1:0]      core_setid, fill_setid;
  logic [WORD_OFFSETBITS-1:0] core_word, fill_word;

  icache_addr_split #(
    .XLEN(XLEN), .SETIDXBITS(SETIDXBITS),
    .BLOCK_OFFSETBITS(BLOCK_OFFSETBITS), .WORD_OFFSETBITS(WORD_OFFSETBITS)
  ) u_core_split (
    .addr(core_req_addr_i), .tag(core_tag), .setid(core_setid), .word(core_word)
  );

  icache_addr_split #(
    .XLEN(XLEN), .SETIDXBITS(SETIDXBITS),
    .BLOCK_OFFSETBITS(BLOCK_OFFSETBITS), .WORD_OFFSETBITS(WORD_OFFSETBITS)
  ) u_fill_split (
    .addr(fill_addr_i), .tag(fill_tag), .setid(fill_setid), .word(fill_word)
  );

  // Refill words are indexed by the beat counter, not by the address.
  logic unused_fill_word;
  assign unused_fill_word = ^fill_word;

  assign adv      = !req_q.valid || arr_ready_i;
  assign fill_pri = starve < STARVE_MAX;

  // Readiness: refill has priority unless the core has hit the starvation bound.
  always_comb begin
    fill_ready_o     = 1'b0;
    core_req_ready_o = 1'b0;
    if (alive && adv) begin
      if (state == FILL) begin
        fill_ready_o = 1'b1;
      end else begin
        fill_ready_o     = fill_pri;
        core_req_ready_o = !(fill_valid_i && fill_pri);
      end
    end
  end

  assign grant_fill = fill_valid_i && fill_ready_o;
  assign grant_core = core_req_valid_i && core_req_ready_o;

  // Next state, beat counter, starvation counter, error flag and output stage.
  always_comb begin
    state_next  = state;
    beat_next   = beat;
    starve_next = starve;
    err_next    = err_q;
    req_d       = req_q;

    if (grant_fill) begin
      if (beat == LAST_BEAT) begin
        state_next = IDLE;
        beat_next  = '0;
      end else begin
        state_next = FILL;
        beat_next  = beat + 1'b1;
      end
      if (fill_last_i != (beat == LAST_BEAT)) begin
        err_next = 1'b1;
      end
    end

    if (!core_req_valid_i || grant_core) begin
      starve_next = '0;
    end else if (adv && (starve != STARVE_MAX)) begin
      starve_next = starve + 1'b1;
    end

    if (adv) begin
      req_d = '0;
      if (grant_fill) begin
        req_d.valid = 1'b1;
        req_d.we    = 1'b1;
        req_d.setid = fill_setid;
        req_d.tag   = fill_tag;
        req_d.word  = beat;
        req_d.wdata = fill_data_i;
      end else if (grant_core) begin
        req_d.valid = 1'b1;
        req_d.setid = core_setid;
        req_d.tag   = core_tag;
        req_d.word  = core_word;
        req_d.wid   = core_req_wid_i;
      end
    end
  end

  // State registers; reset drops any partial burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      beat   <= '0;
      starve <= '0;
      err_q  <= 1'b0;
      req_q  <= '0;
      alive  <= 1'b0;
    end else begin
      state  <= state_next;
      beat   <= beat_next;
      starve <= starve_next;
      err_q  <= err_next;
      req_q  <= req_d;
      alive  <= 1'b1;
    end
  end

  assign arr_valid_o = req_q.valid;
  assign arr_we_o    = req_q.we;
  assign arr_setid_o = req_q.setid;
  assign arr_tag_o   = req_q.tag;
  assign arr_word_o  = req_q.word;
  assign arr_wdata_o = req_q.wdata;
  assign arr_wid_o   = req_q.wid;
  assign err_o       = err_q;

endmodule
`default_nettype wire
